pe_merge: RTL and testbench

- 2:1 stream merger for the systolic-array PE datapath. It is the inverse of the PE 1:2 demux.
- Two valid/ready input lanes, d0 and d1, are arbitrated round-robin onto one registered output lane.
- Each output word carries a source tag, s_out. Downstream logic feeds s_out to a demux select to re-split the stream.
- It sits between PE output ports and the shared partial-sum/drain bus.

---
 rtl/pe_merge.sv | 147 ++++++++++++++
 tb/tb_pe_merge.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_merge.sv
// pe_merge -- 2:1 round-robin stream merger for the systolic-array PE datapath.
//
// Two valid/ready lanes (d0/v0/r0 and d1/v1/r1) are arbitrated onto a single
// registered output lane (q/vq/rq). Every output word carries s_out, the index
// of the lane it came from, so a downstream 1:2 demux can split the stream
// again. On a tie, the lane recorded in the internal priority bit wins. Each
// accepted word flips that bit to the other lane, so sustained contention
// alternates lanes.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   d0, v0, r0 lane-0 data / valid / ready
//   d1, v1, r1 lane-1 data / valid / ready
//   q, s_out   merged data and its source tag (registered)
//   vq, rq     output valid (registered) / downstream ready
//   cnt0, cnt1 per-lane accepted-word counters, present only with MERGE_CNT_EN
//
// Build option
//   MERGE_CNT_EN  when defined, adds the cnt0/cnt1 wrap-around counters,
//                 CNTW bits wide.
module pe_merge #(
  parameter int DWIDTH = 8,
  parameter int CNTW   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] d0,
  input  logic              v0,
  output logic              r0,
  input  logic [DWIDTH-1:0] d1,
  input  logic              v1,
  output logic              r1,
  output logic [DWIDTH-1:0] q,
  output logic              s_out,
  output logic              vq,
  input  logic              rq
`ifdef MERGE_CNT_EN
  ,
  output logic [CNTW-1:0]   cnt0,
  output logic [CNTW-1:0]   cnt1
`endif
);

  logic [DWIDTH-1:0] q_r;
  logic              s_out_r;
  logic              vq_r;
  logic              prio_r;   // lane that wins the next tie
  logic              load_s;   // output register can take a new word this cycle
  logic              g0_s;
  logic              g1_s;

  assign load_s = ~vq_r | rq;

  // Round-robin grant: a lone requester always wins, a tie goes to prio_r.
  always_comb begin
    g0_s = 1'b0;
    g1_s = 1'b0;
    case ({v1, v0})
      2'b01: begin
        g0_s = 1'b1;
      end
      2'b10: begin
        g1_s = 1'b1;
      end
      2'b11: begin
        if (prio_r) begin
          g1_s = 1'b1;
        end else begin
          g0_s = 1'b1;
        end
      end
      default: begin
        g0_s = 1'b0;
        g1_s = 1'b0;
      end
    endcase
  end

  // Readies are held low during reset: a word taken in that cycle would be
  // wiped by the reset and silently lost to the source.
  assign r0 = load_s & g0_s & ~rst;
  assign r1 = load_s & g1_s & ~rst;

  // Output register and tie-break priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r     <= {DWIDTH{1'b0}};
      s_out_r <= 1'b0;
      vq_r    <= 1'b0;
      prio_r  <= 1'b0;
    end else if (load_s) begin
      if (g0_s | g1_s) begin
        q_r     <= g1_s ? d1 : d0;
        s_out_r <= g1_s;
        vq_r    <= 1'b1;
        // Hand the next tie to the lane that just lost.
        prio_r  <= g0_s;
      end else begin
        vq_r    <= 1'b0;
      end
    end else begin
      q_r     <= q_r;
      s_out_r <= s_out_r;
      vq_r    <= vq_r;
      prio_r  <= prio_r;
    end
  end

  assign q     = q_r;
  assign s_out = s_out_r;
  assign vq    = vq_r;

`ifdef MERGE_CNT_EN
  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  logic [CNTW-1:0] cnt0_r;
  logic [CNTW-1:0] cnt1_r;

  // Accepted-word counters; they wrap naturally from all-ones to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_r <= {CNTW{1'b0}};
      cnt1_r <= {CNTW{1'b0}};
    end else begin
      if (r0 & v0) begin
        cnt0_r <= cnt0_r + CNT_ONE;
      end else begin
        cnt0_r <= cnt0_r;
      end
      if (r1 & v1) begin
        cnt1_r <= cnt1_r + CNT_ONE;
      end else begin
        cnt1_r <= cnt1_r;
      end
    end
  end

  assign cnt0 = cnt0_r;
  assign cnt1 = cnt1_r;
`else
  // CNTW only sizes the optional counters; reference it so it is not dangling.
  logic cntw_unused_s;
  assign cntw_unused_s = (CNTW > 32'sd0);
`endif

endmodule

// File: tb/tb_pe_merge.sv
// Self-checking bench for pe_merge: directed scenarios with literal
// expectations, followed by randomized valid/ready traffic compared every
// cycle against a transaction-level model of the merger.
module tb_pe_merge;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic [DW-1:0] d0;
  logic          v0;
  logic          r0;
  logic [DW-1:0] d1;
  logic          v1;
  logic          r1;
  logic [DW-1:0] q;
  logic          s_out;
  logic          vq;
  logic          rq;
`ifdef MERGE_CNT_EN
  logic [CW-1:0] cnt0;
  logic [CW-1:0] cnt1;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  pe_merge #(.DWIDTH(DW), .CNTW(CW)) dut (
    .clk   (clk),
    .rst   (rst),
    .d0    (d0),
    .v0    (v0),
    .r0    (r0),
    .d1    (d1),
    .v1    (v1),
    .r1    (r1),
    .q     (q),
    .s_out (s_out),
    .vq    (vq),
    .rq    (rq)
`ifdef MERGE_CNT_EN
    ,
    .cnt0  (cnt0),
    .cnt1  (cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model: one "output slot" holding at most one word, plus the
  // lane that wins the next tie. Evaluated on the falling edge, where the
  // inputs for the coming rising edge are stable.
  // ---------------------------------------------------------------------
  logic          m_known = 1'b0;
  logic [DW-1:0] m_q;
  logic          m_s;
  logic          m_vq;
  logic          m_prio;
`ifdef MERGE_CNT_EN
  logic [CW-1:0] m_c0;
  logic [CW-1:0] m_c1;
`endif

  always @(negedge clk) begin
    int   win;
    logic slot_free;
    if (m_known) begin
      chk("m_q",     32'(q),     32'(m_q));
      chk("m_s_out", 32'(s_out), 32'(m_s));
      chk("m_vq",    32'(vq),    32'(m_vq));
`ifdef MERGE_CNT_EN
      chk("m_cnt0",  32'(cnt0),  32'(m_c0));
      chk("m_cnt1",  32'(cnt1),  32'(m_c1));
`endif
    end
    // The slot takes a word if it is empty or its word leaves this edge.
    slot_free = !m_vq || rq;
    if (v0 && v1)  win = m_prio ? 1 : 0;
    else if (v0)   win = 0;
    else if (v1)   win = 1;
    else           win = -1;
    if (rst || !m_known || !slot_free) win = -1;
    chk("m_r0", 32'(r0), 32'(win == 0));
    chk("m_r1", 32'(r1), 32'(win == 1));
    if (rst) begin
      m_known = 1'b1;
      m_q     = '0;
      m_s     = 1'b0;
      m_vq    = 1'b0;
      m_prio  = 1'b0;
`ifdef MERGE_CNT_EN
      m_c0    = '0;
      m_c1    = '0;
`endif
    end else if (m_known && slot_free) begin
      if (win >= 0) begin
        m_q    = (win == 1) ? d1 : d0;
        m_s    = (win == 1);
        m_vq   = 1'b1;
        m_prio = (win == 0);
`ifdef MERGE_CNT_EN
        if (win == 0) m_c0 = m_c0 + 1'b1;
        else          m_c1 = m_c1 + 1'b1;
`endif
      end else begin
        m_vq = 1'b0;
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------
  // Stimulus and directed literal expectations.
  // ---------------------------------------------------------------------
  initial begin
    logic [DW-1:0] e;
    logic          a0;
    logic          a1;
    int            n0;
    int            n1;

    rst = 1'b1; v0 = 1'b1; v1 = 1'b1; d0 = 8'h12; d1 = 8'h34; rq = 1'b1;

    // Reset held over two edges with both lanes requesting.
    @(negedge clk);
    chk("rst_r0", 32'(r0), 32'd0);
    chk("rst_r1", 32'(r1), 32'd0);
    chk("rst_vq", 32'(vq), 32'd0);
    chk("rst_q",  32'(q),  32'd0);
    chk("rst_s",  32'(s_out), 32'd0);
    step;
    rst = 1'b0; v1 = 1'b0; v0 = 1'b1; d0 = 8'h01;
    @(negedge clk);
    chk("post_rst_vq", 32'(vq), 32'd0);

    // Single lane streaming 0x01..0x05.
    for (int n = 1; n <= 5; n++) begin
      if (n > 1) @(negedge clk);
      chk("single_r0", 32'(r0), 32'd1);
      chk("single_r1", 32'(r1), 32'd0);
      if (n > 1) begin
        chk("single_q",  32'(q),     32'(n - 1));
        chk("single_s",  32'(s_out), 32'd0);
        chk("single_vq", 32'(vq),    32'd1);
      end
      step;
      if (n < 5) d0 = DW'(n + 1);
      else       v0 = 1'b0;
    end
    @(negedge clk);
    chk("single_q_last", 32'(q), 32'h05);
    chk("single_vq_last", 32'(vq), 32'd1);

    // Reset so the first tie goes to lane 0, then full contention.
    step;
    rst = 1'b1;
    step;
    rst = 1'b0; v0 = 1'b1; v1 = 1'b1; d0 = 8'hA0; d1 = 8'hB0; rq = 1'b1;
    n0 = 0; n1 = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("cont_r0", 32'(r0), 32'(i % 2 == 0));
      chk("cont_r1", 32'(r1), 32'(i % 2 == 1));
      a0 = r0; a1 = r1;
      if (i > 0) begin
        e = ((i - 1) % 2 == 0) ? DW'(8'hA0 + (i - 1) / 2) : DW'(8'hB0 + (i - 1) / 2);
        chk("cont_q", 32'(q), 32'(e));
        chk("cont_s", 32'(s_out), 32'((i - 1) % 2));
      end
      step;
      if (a0) begin n0++; d0 = DW'(8'hA0 + n0); end
      if (a1) begin n1++; d1 = DW'(8'hB0 + n1); end
    end
    @(negedge clk);
    chk("cont_q_last", 32'(q), 32'hB3);
    chk("model_q_pin", 32'(m_q), 32'hB3);
    chk("cont_s_last", 32'(s_out), 32'd1);
    step;
    v0 = 1'b0; v1 = 1'b0;
    step;
    step;

    // Back-pressure: park 0x3C, stall 4 cycles with lane 1 waiting on 0x77.
    v0 = 1'b1; d0 = 8'h3C; rq = 1'b0;
    step;
    v0 = 1'b0; v1 = 1'b1; d1 = 8'h77;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_q",  32'(q),     32'h3C);
      chk("bp_vq", 32'(vq),    32'd1);
      chk("bp_s",  32'(s_out), 32'd0);
      chk("bp_r0", 32'(r0),    32'd0);
      chk("bp_r1", 32'(r1),    32'd0);
      step;
    end
    rq = 1'b1;
    @(negedge clk);
    chk("bp_release_r1", 32'(r1), 32'd1);
    chk("bp_release_q",  32'(q),  32'h3C);
    step;
    v1 = 1'b0;
    @(negedge clk);
    chk("bp_next_q", 32'(q), 32'h77);
    chk("bp_next_s", 32'(s_out), 32'd1);
    chk("model_s_pin", 32'(m_s), 32'd1);

    // Reset while a word is parked under back-pressure.
    step;
    rq = 1'b0;
    step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_vq", 32'(vq), 32'd0);
    chk("mid_rst_q",  32'(q),  32'd0);
    step;
    rq = 1'b1; v0 = 1'b1; v1 = 1'b1; d0 = 8'h11; d1 = 8'h22;
    @(negedge clk);
    chk("mid_rst_tie_r0", 32'(r0), 32'd1);
    chk("mid_rst_tie_r1", 32'(r1), 32'd0);
    step;
    v0 = 1'b0;
    @(negedge clk);
    chk("mid_rst_tie_q", 32'(q), 32'h11);
    chk("mid_rst_tie_s", 32'(s_out), 32'd0);
    chk("mid_rst_r1", 32'(r1), 32'd1);
    step;
    v1 = 1'b0;
    step;

`ifdef MERGE_CNT_EN
    // Counter wrap: 17 lane-1 accepts and 3 lane-0 accepts with CNTW=4.
    rst = 1'b1;
    step;
    rst = 1'b0; rq = 1'b1; v1 = 1'b1;
    for (int k = 0; k < 17; k++) begin
      d1 = DW'($urandom);
      step;
    end
    v1 = 1'b0; v0 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      d0 = DW'($urandom);
      step;
    end
    v0 = 1'b0;
    @(negedge clk);
    chk("cnt1_wrap", 32'(cnt1), 32'd1);
    chk("cnt0_val",  32'(cnt0), 32'd3);
    step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    @(negedge clk);
    chk("cnt0_clr", 32'(cnt0), 32'd0);
    chk("cnt1_clr", 32'(cnt1), 32'd0);
    step;
`endif

    // Randomized traffic; sources hold valid and data until accepted.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      a0 = v0 && r0;
      a1 = v1 && r1;
      step;
      if (!v0 || a0) begin
        v0 = ($urandom_range(0, 2) != 0);
        d0 = DW'($urandom);
      end
      if (!v1 || a1) begin
        v1 = ($urandom_range(0, 2) != 0);
        d1 = DW'($urandom);
      end
      rq  = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 199) == 0);
    end

    rst = 1'b0; v0 = 1'b0; v1 = 1'b0; rq = 1'b1;
    step;
    step;
    @(negedge clk);
    chk("drain_vq", 32'(vq), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
